clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Sequencer for the clock datapath: drives EN/INC/CLR of the seconds and minutes CNT60
//  and the hours counter. RUN mode ripples a 1 Hz tick through the carry chain.
//  Set modes let a user step hours or minutes, or zero the seconds, from two buttons.
//  Sits between the button/prescaler logic and the counter chain.
// PARAMETERS
//  RPT_DELAY   50_000_000  cycles UP must be held before auto-repeat starts (AUTOREPEAT_EN)
//  RPT_PERIOD  10_000_000  cycles between auto-repeat steps (AUTOREPEAT_EN)
//  RPT_W       26          width of the repeat timer; must hold max(RPT_DELAY,RPT_PERIOD)
// PORTS
//  CLK       in   1  system clock, rising edge
//  RST       in   1  asynchronous reset, active-low
//  SEC_TICK  in   1  1-cycle pulse, 1 Hz, from prescaler
//  MODE      in   1  debounced level, mode button
//  UP        in   1  debounced level, step button
//  SEC_CA    in   1  seconds counter carry (high while seconds == 59)
//  MIN_CA    in   1  minutes counter carry (high while minutes == 59)
//  SEC_EN    out  1  seconds counter enable (level)
//  SEC_INC   out  1  seconds step pulse
//  SEC_CLR   out  1  seconds synchronous clear pulse
//  MIN_EN    out  1  minutes enable
//  MIN_INC   out  1  minutes step pulse
//  HOUR_EN   out  1  hours enable
//  HOUR_INC  out  1  hours step pulse
//  FIELD     out  2  0=RUN 1=hour 2=min 3=sec; used by display blink logic
// BEHAVIOUR
//  - A counter steps by 1 in any cycle where its EN and INC are both 1.
//    All EN outputs are held at 1 outside reset.
//  - RST=0: state=RUN; all INC/CLR=0; all EN=0; FIELD=0; edge/repeat regs cleared.
//    Effective immediately; a reset in any set mode returns to RUN.
//  - MODE/UP rising edges: detected with one history flop each (inputs already synchronous).
//    A level held through reset gives no edge after release.
//  - FSM: RUN -MODE-> SET_H -MODE-> SET_M -MODE-> SET_S -MODE-> RUN.
//    FIELD encodes the state.
//  - All outputs are registered: 1-cycle latency from the sampled input event.
//  - RUN:
//    - SEC_INC = SEC_TICK.
//    - MIN_INC = SEC_TICK & SEC_CA.
//    - HOUR_INC = SEC_TICK & SEC_CA & MIN_CA.
//    - Carry inputs are sampled in the same cycle as the tick, so at 59:59 all three
//      INC pulse together.
//  - SET_H: UP edge -> HOUR_INC pulse. SET_M: UP edge -> MIN_INC pulse.
//    No carry propagation into hours in SET_M, minute wrap 59->0 is local.
//  - SET_S: UP edge -> SEC_CLR pulse (seconds to 00). SEC_INC is never asserted here.
//  - In every SET state SEC_TICK is ignored (time is frozen) and the carry inputs are don't-care.
//  - MODE and UP edges in the same cycle: MODE wins, UP is discarded.
//    The new state takes effect for edges from the next cycle on.
//  - Every INC/CLR pulse is exactly 1 cycle wide, with at most one pulse per output per cycle.
// CONFIGURATION
//  CLOCK_SET_AUTOREPEAT_EN defined:
//  - In SET_H/SET_M, UP held high for RPT_DELAY cycles after its edge emits one extra step.
//  - After that, one step every RPT_PERIOD cycles while UP stays high.
//  - The timer clears on UP low, on any MODE edge, and on reset.
//  - No repeat in SET_S or RUN.
//  Undefined:
//  - Exactly one step per UP edge.
//  - Repeat timer logic is absent and the RPT_* parameters are unused.
// TESTING
//  1 RST=0 mid-run with FIELD=2 -> FIELD=0 and all outputs 0 in the same cycle.
//    After release, EN=1 and no INC until the next SEC_TICK.
//  2 RUN, SEC_TICK with SEC_CA=1, MIN_CA=0 -> next cycle SEC_INC=1, MIN_INC=1, HOUR_INC=0.
//    With MIN_CA=1 as well, HOUR_INC=1 too.
//  3 MODE edges x4 -> FIELD 1,2,3,0. Same-cycle MODE+UP in SET_H -> FIELD=2, no HOUR_INC.
//  4 SET_M, 3 UP edges and 5 SEC_TICKs -> exactly 3 MIN_INC pulses, SEC_INC=0, HOUR_INC=0.
//  5 SET_S, UP edge -> one SEC_CLR pulse. Holding UP for 100 cycles gives no further pulses.
//  6 AUTOREPEAT_EN, RPT_DELAY=8, RPT_PERIOD=4, SET_H, UP held 20 cycles
//    -> HOUR_INC at edge+1, +9, +13, +17, +21. Release -> none.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Clock-set sequencer: drives EN/INC/CLR of the sec/min/hour counters from SEC_TICK, MODE and UP.
// Optional UP auto-repeat in SET_H/SET_M is enabled by defining CLOCK_SET_AUTOREPEAT_EN.
`timescale 1ns/1ps

module clock_set_ctrl #(
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000,
    parameter int RPT_W      = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SEC_TICK,
    input  logic       MODE,
    input  logic       UP,
    input  logic       SEC_CA,
    input  logic       MIN_CA,
    output logic       SEC_EN,
    output logic       SEC_INC,
    output logic       SEC_CLR,
    output logic       MIN_EN,
    output logic       MIN_INC,
    output logic       HOUR_EN,
    output logic       HOUR_INC,
    output logic [1:0] FIELD
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_SET_H = 2'd1,
        S_SET_M = 2'd2,
        S_SET_S = 2'd3
    } state_t;

    // The repeat timer must be able to reach both reload values.
    if (((longint'(RPT_DELAY) >> RPT_W) != 0) || ((longint'(RPT_PERIOD) >> RPT_W) != 0)) begin : g_bad_cfg
        $error("clock_set_ctrl: RPT_W too narrow for RPT_DELAY/RPT_PERIOD");
    end

    state_t state_q, state_d;
    logic   en_q, en_d;
    logic   mode_prev_q, mode_prev_d;
    logic   up_prev_q, up_prev_d;
    logic   sec_inc_q, sec_inc_d;
    logic   sec_clr_q, sec_clr_d;
    logic   min_inc_q, min_inc_d;
    logic   hour_inc_q, hour_inc_d;
    logic   mode_edge, up_edge;
    logic   rpt_step;

    // en_q is low for the first cycle after reset, which masks a level held through reset.
    assign mode_edge = en_q & MODE & ~mode_prev_q;
    assign up_edge   = en_q & UP & ~up_prev_q;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] DLY_LIM = RPT_W'(RPT_DELAY);
    localparam logic [RPT_W-1:0] PER_LIM = RPT_W'(RPT_PERIOD);

    logic             rpt_act_q, rpt_act_d;
    logic             rpt_per_q, rpt_per_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             rpt_mode;

    assign rpt_mode = (state_q == S_SET_H) || (state_q == S_SET_M);

    always_comb begin
        rpt_act_d   = rpt_act_q;
        rpt_per_d   = rpt_per_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_step    = 1'b0;
        rpt_cnt_nxt = rpt_cnt_q + 1'b1;
        if (!UP || mode_edge || !rpt_mode) begin
            rpt_act_d = 1'b0;
            rpt_per_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (up_edge) begin
            rpt_act_d = 1'b1;
            rpt_per_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (rpt_act_q) begin
            if (rpt_cnt_nxt == (rpt_per_q ? PER_LIM : DLY_LIM)) begin
                rpt_step  = 1'b1;
                rpt_per_d = 1'b1;
                rpt_cnt_d = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_nxt;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rpt_act_q <= 1'b0;
            rpt_per_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else begin
            rpt_act_q <= rpt_act_d;
            rpt_per_q <= rpt_per_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign rpt_step = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        en_d        = 1'b1;
        mode_prev_d = MODE;
        up_prev_d   = UP;
        sec_inc_d   = 1'b0;
        sec_clr_d   = 1'b0;
        min_inc_d   = 1'b0;
        hour_inc_d  = 1'b0;
        if (mode_edge) begin
            // A same-cycle UP edge is dropped; the new state applies from the next cycle.
            case (state_q)
                S_RUN:   state_d = S_SET_H;
                S_SET_H: state_d = S_SET_M;
                S_SET_M: state_d = S_SET_S;
                default: state_d = S_RUN;
            endcase
        end else begin
            case (state_q)
                S_RUN: begin
                    sec_inc_d  = SEC_TICK;
                    min_inc_d  = SEC_TICK & SEC_CA;
                    hour_inc_d = SEC_TICK & SEC_CA & MIN_CA;
                end
                S_SET_H: hour_inc_d = up_edge | rpt_step;
                S_SET_M: min_inc_d  = up_edge | rpt_step;
                default: sec_clr_d  = up_edge;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_RUN;
            en_q        <= 1'b0;
            mode_prev_q <= 1'b0;
            up_prev_q   <= 1'b0;
            sec_inc_q   <= 1'b0;
            sec_clr_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            hour_inc_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            mode_prev_q <= mode_prev_d;
            up_prev_q   <= up_prev_d;
            sec_inc_q   <= sec_inc_d;
            sec_clr_q   <= sec_clr_d;
            min_inc_q   <= min_inc_d;
            hour_inc_q  <= hour_inc_d;
        end
    end

    assign SEC_EN   = en_q;
    assign MIN_EN   = en_q;
    assign HOUR_EN  = en_q;
    assign SEC_INC  = sec_inc_q;
    assign SEC_CLR  = sec_clr_q;
    assign MIN_INC  = min_inc_q;
    assign HOUR_INC = hour_inc_q;
    assign FIELD    = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expected output vectors queued per step, popped after the edge.
`timescale 1ns/1ps

module tb_clock_set_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SEC_TICK = 1'b0;
    logic       MODE = 1'b0;
    logic       UP = 1'b0;
    logic       SEC_CA = 1'b0;
    logic       MIN_CA = 1'b0;
    logic       SEC_EN, SEC_INC, SEC_CLR, MIN_EN, MIN_INC, HOUR_EN, HOUR_INC;
    logic [1:0] FIELD;
    logic [8:0] obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } exp_t;
    exp_t sb[$];

    clock_set_ctrl #(
        .RPT_DELAY (8),
        .RPT_PERIOD(4),
        .RPT_W     (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SEC_TICK(SEC_TICK),
        .MODE    (MODE),
        .UP      (UP),
        .SEC_CA  (SEC_CA),
        .MIN_CA  (MIN_CA),
        .SEC_EN  (SEC_EN),
        .SEC_INC (SEC_INC),
        .SEC_CLR (SEC_CLR),
        .MIN_EN  (MIN_EN),
        .MIN_INC (MIN_INC),
        .HOUR_EN (HOUR_EN),
        .HOUR_INC(HOUR_INC),
        .FIELD   (FIELD)
    );

    always #5 CLK = ~CLK;

    assign obs = {SEC_EN, SEC_INC, SEC_CLR, MIN_EN, MIN_INC, HOUR_EN, HOUR_INC, FIELD};

    function automatic logic [8:0] ov(input logic en, input logic sinc, input logic sclr,
                                      input logic minc, input logic hinc, input logic [1:0] f);
        return {en, sinc, sclr, en, minc, en, hinc, f};
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Drive one cycle of inputs, queue the registered result, check it just after the edge.
    task automatic step(input string tag, input logic tick, input logic sca, input logic mca,
                        input logic mode, input logic up, input logic sinc, input logic sclr,
                        input logic minc, input logic hinc, input logic [1:0] f);
        exp_t e;
        SEC_TICK = tick;
        SEC_CA   = sca;
        MIN_CA   = mca;
        MODE     = mode;
        UP       = up;
        sb.push_back('{tag, ov(1'b1, sinc, sclr, minc, hinc, f)});
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, obs, 9'h1FF ^ obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    initial begin
        logic hexp;
        #1 RST = 1'b0;
        #1 chk("reset_state", obs, ov(1'b0, 0, 0, 0, 0, 2'd0));
        @(posedge CLK);
        #1 chk("reset_held", obs, ov(1'b0, 0, 0, 0, 0, 2'd0));
        @(negedge CLK);
        RST = 1'b1;
        step("post_rst",   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);

        // RUN: carry chain
        step("run_sca",    1, 1, 0, 0, 0,  1, 0, 1, 0, 2'd0);
        step("run_idle",   0, 1, 1, 0, 0,  0, 0, 0, 0, 2'd0);
        step("run_5959",   1, 1, 1, 0, 0,  1, 0, 1, 1, 2'd0);
        step("run_tick",   1, 0, 1, 0, 0,  1, 0, 0, 0, 2'd0);
        step("run_idle2",  0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);

        // MODE cycling
        step("mode_h",     0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd1);
        step("mode_hold",  1, 0, 0, 1, 0,  0, 0, 0, 0, 2'd1);
        step("mode_rel",   0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1);
        step("mode_m",     0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd2);
        step("mode_rel2",  0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd2);
        step("mode_s",     0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd3);
        step("mode_rel3",  0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd3);
        step("mode_run",   0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd0);
        step("mode_rel4",  0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
        step("to_set_h",   0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd1);
        step("rel_h",      0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1);
        step("mode_up",    0, 0, 0, 1, 1,  0, 0, 0, 0, 2'd2);
        step("rel_mu",     0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd2);

        // SET_M: 3 UP edges, 5 ticks, carries high
        step("m_up1",      1, 1, 1, 0, 1,  0, 0, 1, 0, 2'd2);
        step("m_tick",     1, 1, 1, 0, 0,  0, 0, 0, 0, 2'd2);
        step("m_up2",      0, 1, 1, 0, 1,  0, 0, 1, 0, 2'd2);
        step("m_tick2",    1, 1, 1, 0, 0,  0, 0, 0, 0, 2'd2);
        step("m_tick3",    1, 1, 1, 0, 0,  0, 0, 0, 0, 2'd2);
        step("m_up3",      1, 1, 1, 0, 1,  0, 0, 1, 0, 2'd2);
        step("m_rel",      0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd2);

        // SET_S: one clear per edge, none while held
        step("to_set_s",   0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd3);
        step("rel_s",      1, 0, 0, 0, 0,  0, 0, 0, 0, 2'd3);
        step("s_clr",      1, 0, 0, 0, 1,  0, 1, 0, 0, 2'd3);
        for (int i = 0; i < 100; i++)
            step("s_hold",  1, 0, 0, 0, 1,  0, 0, 0, 0, 2'd3);
        step("s_rel",      0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd3);

        // async reset with FIELD=2, MODE held through reset
        step("r_run",      0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd0);
        step("r_rel1",     0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
        step("r_h",        0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd1);
        step("r_rel2",     0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1);
        step("r_m",        0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd2);
        #3 RST = 1'b0;
        #1 chk("async_rst", obs, ov(1'b0, 0, 0, 0, 0, 2'd0));
        @(posedge CLK);
        #1 chk("rst_edge", obs, ov(1'b0, 0, 0, 0, 0, 2'd0));
        @(negedge CLK);
        RST = 1'b1;
        step("rel_held",   0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd0);
        step("rel_held2",  0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd0);
        step("rel_low",    0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd0);
        step("rel_tick",   1, 0, 0, 0, 0,  1, 0, 0, 0, 2'd0);

        // SET_H: UP held 20 cycles after its edge
        step("h_enter",    0, 0, 0, 1, 0,  0, 0, 0, 0, 2'd1);
        step("h_rel",      0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1);
        step("h_edge",     0, 0, 0, 0, 1,  0, 0, 0, 1, 2'd1);
        for (int k = 1; k <= 20; k++) begin
`ifdef CLOCK_SET_AUTOREPEAT_EN
            hexp = (k == 8) || (k == 12) || (k == 16) || (k == 20);
`else
            hexp = 1'b0;
`endif
            step($sformatf("h_hold%0d", k), 1, 1, 1, 0, 1,  0, 0, 0, hexp, 2'd1);
        end
        for (int i = 0; i < 6; i++)
            step("h_released", 0, 0, 0, 0, 0,  0, 0, 0, 0, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
